imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
- Shares one single-port, fixed-latency instruction memory between the two cores' fetch stages in the dual-core Harvard build.
- Accepts one fetch request at a time from either core using round-robin arbitration.
- Issues the address to the instruction memory, waits the memory read latency, and returns the 32-bit instruction word to the requesting core. The core's field-decode logic consumes that word.

Parameters:
ADDR_W, 32, width of fetch address (byte address, passed through unchanged)
DATA_W, 32, instruction word width
LAT, 1, instruction memory read latency in cycles (legal 1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  core 0 fetch request; held high with addr0 stable until grant0
addr0  in  ADDR_W  core 0 fetch address
grant0  out  1  one-cycle pulse: core 0 request accepted this cycle
rdata0  out  DATA_W  instruction word returned to core 0
rvalid0  out  1  one-cycle pulse: rdata0 holds new instruction
req1  in  1  core 1 fetch request; same rules as req0
addr1  in  ADDR_W  core 1 fetch address
grant1  out  1  core 1 accept pulse
rdata1  out  DATA_W  instruction word returned to core 1
rvalid1  out  1  core 1 return pulse
mem_en  out  1  memory read strobe, one cycle per fetch
mem_addr  out  ADDR_W  memory read address, valid while mem_en=1
mem_rdata  in  DATA_W  memory read data, valid exactly LAT cycles after mem_en
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - grant0/1, rvalid0/1, mem_en, busy all 0.
  - rdata0/1 = 0; mem_addr = 0; wait counter = 0.
  - Priority pointer = core 0 has priority.
- FSM has states IDLE and WAIT. WAIT covers LAT cycles plus one capture cycle.
- IDLE:
  - If any req is high, select the winner. Selection is combinational from req0/req1 and the priority pointer.
  - In the same cycle: assert grant_x=1, mem_en=1, mem_addr=addr_x. Register the winner ID and go to WAIT.
  - After a grant, the priority pointer moves to favour the other core.
  - Only one requester high: it wins regardless of the pointer.
- WAIT:
  - Call the grant/mem_en cycle T.
  - The counter counts LAT cycles. At cycle T+LAT, mem_rdata is sampled into rdata_winner.
  - At T+LAT+1: rvalid_winner=1 for exactly one cycle and state returns to IDLE.
  - A new grant may occur in that same T+LAT+1 cycle.
  - Throughput is one fetch per LAT+1 cycles.
- While in WAIT: no grant is issued, mem_en=0, and req inputs are ignored (requesters keep holding).
- rdata_x holds its value until the next rvalid_x. The non-winning port's rdata is never modified.
- grant0 and grant1 are never high together. rvalid0 and rvalid1 are never high together.
- A req dropped before it is granted is a legal cancel: no grant, no memory access.
- Address width rule: mem_addr = addr_x bit-for-bit. No alignment check and no truncation.
- Reset asserted mid-WAIT:
  - The fetch in progress is aborted immediately.
  - No rvalid is issued and the pointer returns to core 0.
  - Late mem_rdata arriving after reset is ignored.

Test Plan:
- LAT=1, reset released, req0=1, addr0=0x00400000 at cycle 0:
  - Cycle 0: grant0=1, mem_en=1, mem_addr=0x00400000.
  - Memory drives 0x2008000A at cycle 1.
  - Cycle 2: rvalid0=1, rdata0=0x2008000A. rvalid1 and rdata1 stay 0.
- LAT=1, req0 and req1 both high from cycle 0 (addr0=0x00400000, addr1=0x00500000):
  - Cycle 0: grant0.
  - Cycle 2: rvalid0 and grant1 together, mem_addr=0x00500000.
  - Cycle 4: rvalid1.
- Both reqs held high continuously for 8 grants:
  - Grants alternate 0,1,0,1,... with a grant every 2 cycles.
  - busy is high except in grant cycles.
- LAT=3, req1=1, addr1=0x00400010, memory returns 0x8C090004:
  - grant1 at cycle 0.
  - Sample at cycle 3.
  - Cycle 4: rvalid1=1, rdata1=0x8C090004.
- LAT=3, reset pulsed at cycle 2 of a core 0 fetch:
  - All outputs return to 0 immediately.
  - No rvalid0 follows.
  - Simultaneous requests after reset release are granted to core 0 first.
- req0 pulsed high then low during a core 1 WAIT:
  - No grant0 and no extra mem_en.
  - Core 1 completes normally.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, single-port instruction memory
// between two core fetch stages; one fetch in flight at a time.
module imem_fetch_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              grant0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,

  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              grant1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  // The counter value on which mem_rdata is valid (cycle T+LAT).
  localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              prio_q, prio_d;     // 0: core 0 favoured on a tie
  logic              owner_q, owner_d;   // core whose fetch is in flight
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              winner;

  // A lone requester wins outright; the pointer only breaks ties.
  assign winner = (req0 && req1) ? prio_q : req1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    mem_en    = 1'b0;
    mem_addr  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          mem_en = 1'b1;
          if (winner) begin
            grant1   = 1'b1;
            mem_addr = addr1;
          end else begin
            grant0   = 1'b1;
            mem_addr = addr0;
          end
          owner_d = winner;
          prio_d  = ~winner;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (owner_q) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign busy    = (state_q != S_IDLE);

  a_one_grant : assert property (@(posedge clk) disable iff (reset) !(grant0 && grant1));
  a_one_rvalid : assert property (@(posedge clk) disable iff (reset) !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: one instance at LAT=1 (a_*) and one at
// LAT=3 (b_*), each with a behavioural fixed-latency memory.
module tb_imem_fetch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: mem_word = 32'h2008_000A;
      32'h0050_0000: mem_word = 32'h3C01_1001;
      32'h0040_0010: mem_word = 32'h8C09_0004;
      default:       mem_word = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // ---------------- LAT = 1 instance ----------------
  logic        a_reset, a_req0, a_req1, a_grant0, a_grant1, a_rvalid0, a_rvalid1;
  logic        a_mem_en, a_busy;
  logic [31:0] a_addr0, a_addr1, a_rdata0, a_rdata1, a_mem_addr, a_mem_rdata;
  logic [5:0]  a_st;

  imem_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut_a (
    .clk(clk), .reset(a_reset),
    .req0(a_req0), .addr0(a_addr0), .grant0(a_grant0), .rdata0(a_rdata0), .rvalid0(a_rvalid0),
    .req1(a_req1), .addr1(a_addr1), .grant1(a_grant1), .rdata1(a_rdata1), .rvalid1(a_rvalid1),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  // status vector: {grant0, grant1, mem_en, busy, rvalid0, rvalid1}
  assign a_st = {a_grant0, a_grant1, a_mem_en, a_busy, a_rvalid0, a_rvalid1};

  logic        a_v = 1'b0;
  logic [31:0] a_d = '0;
  always @(posedge clk) begin
    a_v <= a_mem_en;
    a_d <= mem_word(a_mem_addr);
  end
  assign a_mem_rdata = a_v ? a_d : 32'hDEAD_BEEF;

  // ---------------- LAT = 3 instance ----------------
  logic        b_reset, b_req0, b_req1, b_grant0, b_grant1, b_rvalid0, b_rvalid1;
  logic        b_mem_en, b_busy;
  logic [31:0] b_addr0, b_addr1, b_rdata0, b_rdata1, b_mem_addr, b_mem_rdata;
  logic [5:0]  b_st;

  imem_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u_dut_b (
    .clk(clk), .reset(b_reset),
    .req0(b_req0), .addr0(b_addr0), .grant0(b_grant0), .rdata0(b_rdata0), .rvalid0(b_rvalid0),
    .req1(b_req1), .addr1(b_addr1), .grant1(b_grant1), .rdata1(b_rdata1), .rvalid1(b_rvalid1),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  assign b_st = {b_grant0, b_grant1, b_mem_en, b_busy, b_rvalid0, b_rvalid1};

  logic [2:0]  b_v = '0;
  logic [31:0] b_d0 = '0, b_d1 = '0, b_d2 = '0;
  always @(posedge clk) begin
    b_v  <= {b_v[1:0], b_mem_en};
    b_d0 <= mem_word(b_mem_addr);
    b_d1 <= b_d0;
    b_d2 <= b_d1;
  end
  assign b_mem_rdata = b_v[2] ? b_d2 : 32'hDEAD_BEEF;

  // Advance to just after the next rising edge; callers drive inputs, then #1 and sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_reset = 1'b1; a_req0 = 1'b0; a_req1 = 1'b0;
    step();
    a_reset = 1'b0;
  endtask

  task automatic reset_b();
    b_reset = 1'b1; b_req0 = 1'b0; b_req1 = 1'b0;
    step();
    b_reset = 1'b0;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_req0 = 1'b0; a_req1 = 1'b0; a_addr0 = '0; a_addr1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_addr0 = '0; b_addr1 = '0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (a_st !== 6'b000000) begin n_err++; $display("FAIL reset_a_status: got %b want %b", a_st, 6'b000000); end
    n_cmp++; if (b_st !== 6'b000000) begin n_err++; $display("FAIL reset_b_status: got %b want %b", b_st, 6'b000000); end
    n_cmp++; if ({a_rdata0, a_rdata1, a_mem_addr} !== 96'd0) begin n_err++; $display("FAIL reset_a_data: got %h want 0", {a_rdata0, a_rdata1, a_mem_addr}); end
    n_cmp++; if ({b_rdata0, b_rdata1, b_mem_addr} !== 96'd0) begin n_err++; $display("FAIL reset_b_data: got %h want 0", {b_rdata0, b_rdata1, b_mem_addr}); end
    step();
    a_reset = 1'b0; b_reset = 1'b0;
    #1;
    n_cmp++; if (a_st !== 6'b000000) begin n_err++; $display("FAIL reset_a_idle: got %b want %b", a_st, 6'b000000); end
  endtask

  task automatic test_single_fetch();
    reset_a();
    step(); a_req0 = 1'b1; a_addr0 = 32'h0040_0000; #1;
    n_cmp++; if (a_st !== 6'b101000) begin n_err++; $display("FAIL single_c0_status: got %b want %b", a_st, 6'b101000); end
    n_cmp++; if (a_mem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL single_c0_mem_addr: got %h want %h", a_mem_addr, 32'h0040_0000); end
    step(); a_req0 = 1'b0; #1;
    n_cmp++; if (a_st !== 6'b000100) begin n_err++; $display("FAIL single_c1_status: got %b want %b", a_st, 6'b000100); end
    step(); #1;
    n_cmp++; if (a_st !== 6'b000010) begin n_err++; $display("FAIL single_c2_status: got %b want %b", a_st, 6'b000010); end
    n_cmp++; if (a_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL single_c2_rdata0: got %h want %h", a_rdata0, 32'h2008_000A); end
    n_cmp++; if (a_rdata1 !== 32'h0) begin n_err++; $display("FAIL single_c2_rdata1: got %h want %h", a_rdata1, 32'h0); end
    step(); #1;
    n_cmp++; if (a_st !== 6'b000000) begin n_err++; $display("FAIL single_c3_status: got %b want %b", a_st, 6'b000000); end
    n_cmp++; if (a_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL single_c3_rdata0_hold: got %h want %h", a_rdata0, 32'h2008_000A); end
  endtask

  task automatic test_both_reqs();
    reset_a();
    step();
    a_req0 = 1'b1; a_addr0 = 32'h0040_0000;
    a_req1 = 1'b1; a_addr1 = 32'h0050_0000;
    #1;
    n_cmp++; if (a_st !== 6'b101000) begin n_err++; $display("FAIL both_c0_status: got %b want %b", a_st, 6'b101000); end
    n_cmp++; if (a_mem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL both_c0_mem_addr: got %h want %h", a_mem_addr, 32'h0040_0000); end
    step(); a_req0 = 1'b0; #1;
    n_cmp++; if (a_st !== 6'b000100) begin n_err++; $display("FAIL both_c1_status: got %b want %b", a_st, 6'b000100); end
    step(); #1;
    n_cmp++; if (a_st !== 6'b011010) begin n_err++; $display("FAIL both_c2_status: got %b want %b", a_st, 6'b011010); end
    n_cmp++; if (a_mem_addr !== 32'h0050_0000) begin n_err++; $display("FAIL both_c2_mem_addr: got %h want %h", a_mem_addr, 32'h0050_0000); end
    n_cmp++; if (a_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL both_c2_rdata0: got %h want %h", a_rdata0, 32'h2008_000A); end
    step(); a_req1 = 1'b0; #1;
    n_cmp++; if (a_st !== 6'b000100) begin n_err++; $display("FAIL both_c3_status: got %b want %b", a_st, 6'b000100); end
    step(); #1;
    n_cmp++; if (a_st !== 6'b000001) begin n_err++; $display("FAIL both_c4_status: got %b want %b", a_st, 6'b000001); end
    n_cmp++; if (a_rdata1 !== 32'h3C01_1001) begin n_err++; $display("FAIL both_c4_rdata1: got %h want %h", a_rdata1, 32'h3C01_1001); end
    n_cmp++; if (a_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL both_c4_rdata0_hold: got %h want %h", a_rdata0, 32'h2008_000A); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_st;
    logic       g, w, pw;
    reset_a();
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) begin
        a_req0 = 1'b1; a_addr0 = 32'h0040_0000;
        a_req1 = 1'b1; a_addr1 = 32'h0050_0000;
      end
      #1;
      g  = (k % 2 == 0);
      w  = ((k / 2) % 2) == 1;
      pw = (((k - 2) / 2) % 2) == 1;
      exp_st = {g && !w, g && w, g, !g, (k >= 2) && g && !pw, (k >= 2) && g && pw};
      n_cmp++; if (a_st !== exp_st) begin n_err++; $display("FAIL b2b_status[%0d]: got %b want %b", k, a_st, exp_st); end
      if (exp_st[1]) begin
        n_cmp++; if (a_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL b2b_rdata0[%0d]: got %h want %h", k, a_rdata0, 32'h2008_000A); end
      end
      if (exp_st[0]) begin
        n_cmp++; if (a_rdata1 !== 32'h3C01_1001) begin n_err++; $display("FAIL b2b_rdata1[%0d]: got %h want %h", k, a_rdata1, 32'h3C01_1001); end
      end
    end
    step(); a_req0 = 1'b0; a_req1 = 1'b0; #1;
    n_cmp++; if (a_st !== 6'b000001) begin n_err++; $display("FAIL b2b_drain_status: got %b want %b", a_st, 6'b000001); end
    step(); #1;
    n_cmp++; if (a_st !== 6'b000000) begin n_err++; $display("FAIL b2b_idle_status: got %b want %b", a_st, 6'b000000); end
  endtask

  task automatic test_lat3();
    reset_b();
    step(); b_req1 = 1'b1; b_addr1 = 32'h0040_0010; #1;
    n_cmp++; if (b_st !== 6'b011000) begin n_err++; $display("FAIL lat3_c0_status: got %b want %b", b_st, 6'b011000); end
    n_cmp++; if (b_mem_addr !== 32'h0040_0010) begin n_err++; $display("FAIL lat3_c0_mem_addr: got %h want %h", b_mem_addr, 32'h0040_0010); end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) b_req1 = 1'b0;
      #1;
      n_cmp++; if (b_st !== 6'b000100) begin n_err++; $display("FAIL lat3_wait_status[%0d]: got %b want %b", c, b_st, 6'b000100); end
    end
    step(); #1;
    n_cmp++; if (b_st !== 6'b000001) begin n_err++; $display("FAIL lat3_c4_status: got %b want %b", b_st, 6'b000001); end
    n_cmp++; if (b_rdata1 !== 32'h8C09_0004) begin n_err++; $display("FAIL lat3_c4_rdata1: got %h want %h", b_rdata1, 32'h8C09_0004); end
    n_cmp++; if (b_rdata0 !== 32'h0) begin n_err++; $display("FAIL lat3_c4_rdata0: got %h want %h", b_rdata0, 32'h0); end
  endtask

  // Runs straight after test_lat3 so rdata1 is non-zero going into the reset.
  task automatic test_reset_mid_wait();
    step(); b_req0 = 1'b1; b_addr0 = 32'h0040_0000; #1;
    n_cmp++; if (b_st !== 6'b101000) begin n_err++; $display("FAIL rstmid_c0_status: got %b want %b", b_st, 6'b101000); end
    step(); b_req0 = 1'b0; #1;
    step(); b_reset = 1'b1; #1;
    n_cmp++; if (b_st !== 6'b000000) begin n_err++; $display("FAIL rstmid_c2_status: got %b want %b", b_st, 6'b000000); end
    n_cmp++; if ({b_rdata0, b_rdata1, b_mem_addr} !== 96'd0) begin n_err++; $display("FAIL rstmid_c2_data: got %h want 0", {b_rdata0, b_rdata1, b_mem_addr}); end
    for (int c = 3; c <= 4; c++) begin
      step();
      if (c == 3) b_reset = 1'b0;
      #1;
      n_cmp++; if (b_st !== 6'b000000) begin n_err++; $display("FAIL rstmid_late_status[%0d]: got %b want %b", c, b_st, 6'b000000); end
      n_cmp++; if (b_rdata0 !== 32'h0) begin n_err++; $display("FAIL rstmid_late_rdata0[%0d]: got %h want %h", c, b_rdata0, 32'h0); end
    end
    step();
    b_req0 = 1'b1; b_addr0 = 32'h0040_0000;
    b_req1 = 1'b1; b_addr1 = 32'h0050_0000;
    #1;
    n_cmp++; if (b_st !== 6'b101000) begin n_err++; $display("FAIL rstmid_regrant_status: got %b want %b", b_st, 6'b101000); end
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) begin b_req0 = 1'b0; b_req1 = 1'b0; end
      #1;
      n_cmp++; if (b_st !== 6'b000100) begin n_err++; $display("FAIL rstmid_wait_status[%0d]: got %b want %b", c, b_st, 6'b000100); end
    end
    step(); #1;
    n_cmp++; if (b_st !== 6'b000010) begin n_err++; $display("FAIL rstmid_rvalid_status: got %b want %b", b_st, 6'b000010); end
    n_cmp++; if (b_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL rstmid_rdata0: got %h want %h", b_rdata0, 32'h2008_000A); end
  endtask

  task automatic test_cancel();
    int n_en;
    step(); b_req1 = 1'b1; b_addr1 = 32'h0040_0010; #1;
    n_cmp++; if (b_st !== 6'b011000) begin n_err++; $display("FAIL cancel_c0_status: got %b want %b", b_st, 6'b011000); end
    n_en = 0;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) begin b_req1 = 1'b0; b_req0 = 1'b1; b_addr0 = 32'h0040_0000; end
      if (c == 2) b_req0 = 1'b0;
      #1;
      n_cmp++; if (b_st !== 6'b000100) begin n_err++; $display("FAIL cancel_wait_status[%0d]: got %b want %b", c, b_st, 6'b000100); end
      if (b_mem_en) n_en++;
    end
    step(); #1;
    if (b_mem_en) n_en++;
    n_cmp++; if (b_st !== 6'b000001) begin n_err++; $display("FAIL cancel_c4_status: got %b want %b", b_st, 6'b000001); end
    n_cmp++; if (b_rdata1 !== 32'h8C09_0004) begin n_err++; $display("FAIL cancel_c4_rdata1: got %h want %h", b_rdata1, 32'h8C09_0004); end
    n_cmp++; if (b_rdata0 !== 32'h2008_000A) begin n_err++; $display("FAIL cancel_c4_rdata0_hold: got %h want %h", b_rdata0, 32'h2008_000A); end
    step(); #1;
    if (b_mem_en) n_en++;
    n_cmp++; if (b_st !== 6'b000000) begin n_err++; $display("FAIL cancel_c5_status: got %b want %b", b_st, 6'b000000); end
    n_cmp++; if (n_en !== 0) begin n_err++; $display("FAIL cancel_extra_mem_en: got %0d want %0d", n_en, 0); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_both_reqs();
    test_back_to_back();
    test_lat3();
    test_reset_mid_wait();
    test_cancel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
